// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared types and constants for the bit serializer
// State encoding, width ceiling and the parity helper used by bit_serializer.
package bit_serializer_pkg;

  localparam int SER_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  function automatic logic even_parity(input logic [SER_MAX_WIDTH-1:0] i_word);
    return ^i_word;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// rtl/ser_shift_reg.sv - load/shift register feeding the serial output bit
// o_next_head is the bit that sits at the head once this edge's load/shift lands.
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_next_head
);

  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;

  always_comb begin
    w_sr_next = r_sr;
    if (i_load) begin
      w_sr_next = i_data;
    end else if (i_shift) begin
      w_sr_next = (MSB_FIRST != 0) ? (r_sr << 1) : (r_sr >> 1);
    end
  end

  assign o_next_head = (MSB_FIRST != 0) ? w_sr_next[WIDTH-1] : w_sr_next[0];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_next;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial converter with ready/valid intake
// Optional trailing even-parity bit when BIT_SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  ser_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ser_out;
  logic          r_ser_valid;
  logic          w_accept;
  logic          w_shift;
  logic          w_last;
  logic          w_next_head;

  assign w_last  = (r_state == SHIFT) && (r_cnt == '0);
  assign w_shift = (r_state == SHIFT) && (r_cnt != '0);

`ifdef BIT_SERIALIZER_PARITY_EN
  logic r_parity;
  // The parity cycle is the final output cycle, so it carries data_ready.
  assign data_ready = (r_state == IDLE) || (r_state == PARITY);
`else
  assign data_ready = (r_state == IDLE) || w_last;
`endif

  assign w_accept  = data_valid && data_ready;
  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign busy      = (r_state != IDLE);

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk         (clk),
    .rstb        (rstb),
    .i_load      (w_accept),
    .i_shift     (w_shift),
    .i_data      (data_in),
    .o_next_head (w_next_head)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state     <= SHIFT;
      r_cnt       <= CNT_LOAD;
      r_ser_out   <= w_next_head;
      r_ser_valid <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      r_parity    <= even_parity(SER_MAX_WIDTH'(data_in));
`endif
    end else if (w_shift) begin
      r_cnt     <= r_cnt - 1'b1;
      r_ser_out <= w_next_head;
`ifdef BIT_SERIALIZER_PARITY_EN
    end else if (w_last) begin
      r_state   <= PARITY;
      r_ser_out <= r_parity;
`endif
    end else begin
      // End of word with nothing queued: drive zeros so the detector idles.
      r_state     <= IDLE;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
    end
  end

endmodule
